instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of instruction decode.
- Owns the PC and issues word addresses to a synchronous-read instruction memory.
- Registers the returned word into the IF/ID output (instr, pc, valid), which decode consumes.
- Honours pipeline stall, EX-stage branch/jump redirect and decode-detected halt.

Parameters:
- PC_W, 16, width of word-addressed PC and imem address.
- RESET_PC, 0, first address fetched after reset.
- NOP_INSTR, 32'h0000_0000, value driven on instr_IF while not valid.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID outputs and PC.
- branch_taken  in  1  EX resolved redirect this cycle.
- branch_target  in  PC_W  redirect word address.
- hlt  in  1  decode has a HALT in ID.
- imem_addr  out  PC_W  instruction memory address (combinational).
- imem_re  out  1  instruction memory read enable.
- imem_rdata  in  32  data for the address issued the previous cycle.
- instr_IF  out  32  fetched instruction to decode.
- pc_IF  out  PC_W  address of instr_IF.
- pc_plus1_IF  out  PC_W  pc_IF+1, for JAL link.
- valid_IF  out  1  instr_IF is a real instruction.
- halted  out  1  fetch has stopped permanently.

Behaviour:
- Internal registers:
  - pc: next address to issue.
  - inflight_pc, inflight_valid: address read last cycle.
  - IF/ID output regs.
  - state: RUN or HALTED.
- Reset (rst=1 at edge):
  - pc=RESET_PC, inflight_valid=0, inflight_pc=0.
  - valid_IF=0, instr_IF=NOP_INSTR, pc_IF=0, pc_plus1_IF=0.
  - state=RUN, halted=0.
  - Reset mid-stall, mid-redirect or in HALTED overrides everything.
- Latency: address issued in cycle n appears on instr_IF/valid_IF from cycle n+2. One instruction per cycle when unstalled.
- Priority per cycle: rst > branch_taken > hlt > stall > normal.
- Normal (RUN, no stall/redirect):
  - imem_addr=pc, imem_re=1.
  - inflight_pc<=pc, inflight_valid<=1, pc<=pc+1 (wraps mod 2^PC_W).
  - IF/ID<=(imem_rdata, inflight_pc, inflight_pc+1, inflight_valid).
- Stall (RUN, stall=1, no redirect):
  - IF/ID, pc and inflight regs all hold.
  - imem_addr=inflight_pc, imem_re=inflight_valid, so the memory keeps returning the in-flight word and nothing is lost on release.
- Redirect (branch_taken=1, any stall):
  - imem_addr=branch_target, imem_re=1.
  - inflight_pc<=branch_target, inflight_valid<=1, pc<=branch_target+1.
  - valid_IF<=0 and instr_IF<=NOP_INSTR, squashing the wrong-path word in ID.
  - A redirect in HALTED returns state to RUN, since that halt was on the wrong path.
- Halt (hlt=1, no redirect):
  - state<=HALTED, halted<=1, imem_re=0.
  - inflight_valid<=0, valid_IF<=0, instr_IF<=NOP_INSTR.
  - pc frozen at its current value.
- HALTED: imem_re=0, outputs stay invalid. Leaves only on reset or redirect.
- pc_plus1_IF is computed PC_W wide and wraps.
- When valid_IF=0, instr_IF is always NOP_INSTR, never stale data.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (ADD..TM, HALT=5'b11111).
  - NOP_INSTR.
  - typedef if_id_t {instr, pc, pc_plus1, valid}, reused by the ID/EX register.
  - enum fetch_state_t {RUN, HALTED}.
- One sub-module: pc_reg (PC register with load/increment/hold). Everything else stays flat.

Test Plan:
- Reset, then 6 free-run cycles with mem[i]=i+0x100 -> imem_addr 0,1,2,…; valid_IF first high in cycle 2 with instr_IF=0x100, pc_IF=0, pc_plus1_IF=1, then increments each cycle.
- Stall for 3 cycles while pc_IF=3 -> instr_IF=0x103 held 3 cycles, imem_addr=4 throughout; after release the next instr is 0x104 with no skip or duplicate.
- branch_taken with target=0x20 while pc_IF=5 -> next cycle valid_IF=0 and instr=NOP; the cycle after, instr=mem[0x20], pc_IF=0x20, then 0x21.
- branch_taken and stall in the same cycle -> redirect wins; imem_addr=target that cycle.
- hlt at pc_IF=7 -> imem_re=0 next cycle, halted=1, valid_IF=0 for 10 cycles; a later branch_taken to 0x40 resumes fetch at 0x40.
- PC_W=4, pc=15, free run -> imem_addr wraps 15→0, pc_plus1_IF of pc_IF=15 is 0; rst asserted mid-run -> pc_IF=0, valid_IF=0 on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, the NOP encoding, the IF/ID record and fetch FSM states.
// Pure declarations; no logic and no flow control.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SW   = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_BNE  = 5'd11;
  localparam logic [4:0] OP_JAL  = 5'd12;
  localparam logic [4:0] OP_JALR = 5'd13;
  localparam logic [4:0] OP_LUI  = 5'd14;
  localparam logic [4:0] OP_TM   = 5'd15;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          CPU_PC_W  = 16;

  // Pipeline register record, shared by IF/ID and ID/EX.
  typedef struct packed {
    logic [31:0]         instr;
    logic [CPU_PC_W-1:0] pc;
    logic [CPU_PC_W-1:0] pc_plus1;
    logic                valid;
  } if_id_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, otherwise holds.
// Single-cycle update; the caller gates inc to express stall.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues PC to sync-read imem, word reaches IF/ID two cycles after issue.
// Stall freezes everything and re-reads the in-flight address; redirect squashes ID and wins over stall/halt.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            hlt,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_re,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_IF,
  output logic [PC_W-1:0] pc_IF,
  output logic [PC_W-1:0] pc_plus1_IF,
  output logic            valid_IF,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight_valid;
  logic            advance;

  assign advance = (state == RUN) && !branch_taken && !hlt && !stall;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (branch_taken),
    .load_val (branch_target + PC_ONE),
    .inc      (advance),
    .pc       (pc)
  );

  // During a stall the memory is re-pointed at the in-flight word so its data survives release.
  always_comb begin
    imem_addr = pc;
    imem_re   = 1'b0;
    if (branch_taken) begin
      imem_addr = branch_target;
      imem_re   = 1'b1;
    end else if (state == HALTED || hlt) begin
      imem_re   = 1'b0;
    end else if (stall) begin
      imem_addr = inflight_pc;
      imem_re   = inflight_valid;
    end else begin
      imem_re   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      halted         <= 1'b0;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      instr_IF       <= NOP_INSTR;
      pc_IF          <= '0;
      pc_plus1_IF    <= '0;
      valid_IF       <= 1'b0;
    end else if (branch_taken) begin
      // A halt seen before the redirect was on the wrong path, so resume.
      state          <= RUN;
      halted         <= 1'b0;
      inflight_pc    <= branch_target;
      inflight_valid <= 1'b1;
      instr_IF       <= NOP_INSTR;
      valid_IF       <= 1'b0;
    end else if (state == RUN) begin
      if (hlt) begin
        state          <= HALTED;
        halted         <= 1'b1;
        inflight_valid <= 1'b0;
        instr_IF       <= NOP_INSTR;
        valid_IF       <= 1'b0;
      end else if (!stall) begin
        inflight_pc    <= pc;
        inflight_valid <= 1'b1;
        instr_IF       <= inflight_valid ? imem_rdata : NOP_INSTR;
        pc_IF          <= inflight_pc;
        pc_plus1_IF    <= inflight_pc + PC_ONE;
        valid_IF       <= inflight_valid;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle table through a scoreboard queue, plus a 4-bit PC wrap/reset sequence.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, hlt = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic [15:0] imem_addr, pc_IF, pc_plus1_IF;
  logic        imem_re, valid_IF, halted;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_IF;

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .hlt(hlt), .imem_addr(imem_addr),
    .imem_re(imem_re), .imem_rdata(imem_rdata), .instr_IF(instr_IF),
    .pc_IF(pc_IF), .pc_plus1_IF(pc_plus1_IF), .valid_IF(valid_IF), .halted(halted)
  );

  always_ff @(posedge clk) if (imem_re) imem_rdata <= 32'h100 + {16'h0, imem_addr};

  logic        rst_b = 1'b1;
  logic [3:0]  addr_b, pc_b, pc1_b;
  logic        re_b, valid_b, halted_b;
  logic [31:0] rdata_b = 32'h0;
  logic [31:0] instr_b;

  instr_fetch #(.PC_W(4), .RESET_PC(4'hF), .NOP_INSTR(NOP)) dut_b (
    .clk(clk), .rst(rst_b), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(4'h0), .hlt(1'b0), .imem_addr(addr_b),
    .imem_re(re_b), .imem_rdata(rdata_b), .instr_IF(instr_b),
    .pc_IF(pc_b), .pc_plus1_IF(pc1_b), .valid_IF(valid_b), .halted(halted_b)
  );

  always_ff @(posedge clk) if (re_b) rdata_b <= 32'h100 + {28'h0, addr_b};

  // im: 0 = no imem check, 1 = imem_re must be 0, 2 = imem_re=1 and addr checked
  // cp: 0 = no pc check, 1 = pc_IF=pc and pc_plus1_IF=pc+1, 2 = both zero (reset)
  typedef struct {
    logic        rst, stall, br, hlt;
    logic [15:0] tgt;
    int          im;
    logic [15:0] addr;
    logic        valid;
    logic [31:0] instr;
    int          cp;
    logic [15:0] pc;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(input logic r, input logic s, input logic b, input logic [15:0] t,
                             input logic h, input int im, input logic [15:0] a, input logic vl,
                             input logic [31:0] ins, input int cp, input logic [15:0] p,
                             input logic hal);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.hlt = h; x.im = im; x.addr = a;
    x.valid = vl; x.instr = ins; x.cp = cp; x.pc = p; x.halted = hal;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h0 , 0,NOP         , 2,16'h0 , 0)); // c0 reset state
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h1 , 0,NOP         , 0,16'h0 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h2 , 1,32'h100     , 1,16'h0 , 0)); // first valid word
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h3 , 1,32'h101     , 1,16'h1 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h4 , 1,32'h102     , 1,16'h2 , 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(0,1,0,16'h0,0, 2,16'h4 , 1,32'h103     , 1,16'h3 , 0)); // stall x3
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h5 , 1,32'h103     , 1,16'h3 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h6 , 1,32'h104     , 1,16'h4 , 0)); // no skip/dup
    vecs.push_back(v(0,0,1,16'h20,0, 2,16'h20, 1,32'h105     , 1,16'h5 , 0)); // redirect
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h21, 0,NOP         , 0,16'h0 , 0)); // squashed
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h22, 1,32'h120     , 1,16'h20, 0));
    vecs.push_back(v(0,1,1,16'h30,0, 2,16'h30, 1,32'h121     , 1,16'h21, 0)); // redirect beats stall
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h31, 0,NOP         , 0,16'h0 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h32, 1,32'h130     , 1,16'h30, 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h33, 1,32'h131     , 1,16'h31, 0));
    vecs.push_back(v(0,0,1,16'h6 ,0, 2,16'h6 , 1,32'h132     , 1,16'h32, 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h7 , 0,NOP         , 0,16'h0 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h8 , 1,32'h106     , 1,16'h6 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,1, 1,16'h0 , 1,32'h107     , 1,16'h7 , 0)); // halt at pc_IF=7
    for (int k = 0; k < 10; k++)
      vecs.push_back(v(0,0,0,16'h0,0, 1,16'h0 , 0,NOP         , 0,16'h0 , 1)); // halted
    vecs.push_back(v(0,0,1,16'h40,0, 2,16'h40, 0,NOP         , 0,16'h0 , 1)); // resume
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h41, 0,NOP         , 0,16'h0 , 0));
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h42, 1,32'h140     , 1,16'h40, 0));
    vecs.push_back(v(1,0,0,16'h0 ,0, 0,16'h0 , 1,32'h141     , 1,16'h41, 0)); // reset mid-run
    vecs.push_back(v(0,0,0,16'h0 ,0, 2,16'h0 , 0,NOP         , 2,16'h0 , 0));

    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt; hlt = vecs[i].hlt;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      if (e.im != 0) chk($sformatf("c%0d imem_re", i), {31'h0, imem_re}, {31'h0, e.im == 2});
      if (e.im == 2) chk($sformatf("c%0d imem_addr", i), {16'h0, imem_addr}, {16'h0, e.addr});
      chk($sformatf("c%0d valid_IF", i), {31'h0, valid_IF}, {31'h0, e.valid});
      chk($sformatf("c%0d instr_IF", i), instr_IF, e.instr);
      chk($sformatf("c%0d halted", i), {31'h0, halted}, {31'h0, e.halted});
      if (e.cp == 1) begin
        chk($sformatf("c%0d pc_IF", i), {16'h0, pc_IF}, {16'h0, e.pc});
        chk($sformatf("c%0d pc_plus1_IF", i), {16'h0, pc_plus1_IF}, {16'h0, e.pc + 16'h1});
      end else if (e.cp == 2) begin
        chk($sformatf("c%0d pc_IF", i), {16'h0, pc_IF}, 32'h0);
        chk($sformatf("c%0d pc_plus1_IF", i), {16'h0, pc_plus1_IF}, 32'h0);
      end
    end
    rst = 1'b0; branch_taken = 1'b0; stall = 1'b0; hlt = 1'b0;

    // 4-bit PC starting at 15: address and link value both wrap, then reset mid-run.
    @(negedge clk); rst_b = 1'b0; #1;
    chk("w0 addr", {28'h0, addr_b}, 32'hF);
    chk("w0 re", {31'h0, re_b}, 32'h1);
    chk("w0 valid", {31'h0, valid_b}, 32'h0);
    @(negedge clk); #1;
    chk("w1 addr wrap", {28'h0, addr_b}, 32'h0);
    @(negedge clk); #1;
    chk("w2 valid", {31'h0, valid_b}, 32'h1);
    chk("w2 instr", instr_b, 32'h10F);
    chk("w2 pc", {28'h0, pc_b}, 32'hF);
    chk("w2 pc_plus1 wrap", {28'h0, pc1_b}, 32'h0);
    @(negedge clk); rst_b = 1'b1; #1;
    chk("w3 instr", instr_b, 32'h100);
    chk("w3 pc", {28'h0, pc_b}, 32'h0);
    chk("w3 pc_plus1", {28'h0, pc1_b}, 32'h1);
    @(negedge clk); rst_b = 1'b0; #1;
    chk("w4 valid after rst", {31'h0, valid_b}, 32'h0);
    chk("w4 pc after rst", {28'h0, pc_b}, 32'h0);
    chk("w4 instr after rst", instr_b, NOP);
    chk("w4 addr after rst", {28'h0, addr_b}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
